// File: rtl/onehot_pkg.sv
// Shared types and default sizes for the one-hot encoder block.
// Imported by the priority encoder and the capture FSM.
package onehot_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned W_DEF  = 3;
  localparam int unsigned CW_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-set-bit encoder with zero / multi-hot detection.
// Purely combinational; zero and multi are mutually exclusive.
module onehot_prio_enc
  import onehot_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] index,
  output logic         zero,
  output logic         multi
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) index = W'(i);
    end
  end

  // clearing the lowest set bit leaves a residue only when multi-hot
  always_comb begin
    zero  = (vec == '0);
    multi = ((vec & (vec - N'(1))) != '0);
  end

endmodule

// File: rtl/onehot_encoder_block.sv
// Captures a one-hot cell vector, encodes it and holds the result
// under a valid/ready handshake with sticky error tracking.
module onehot_encoder_block
  import onehot_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  onehot_in,
  input  logic          sample,
  input  logic          out_ready,
  input  logic          clr_err,
  output logic          out_valid,
  output logic [W-1:0]  out_index,
  output logic          out_zero,
  output logic          out_multi,
  output logic          err_sticky,
  output logic          ovr_sticky,
  output logic [CW-1:0] err_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t         state;
  logic [W-1:0]   enc_index;
  logic           enc_zero;
  logic           enc_multi;
  logic           capture;
  logic           drop;
  logic           illegal;
  logic [CW-1:0]  cnt_base;

  onehot_prio_enc #(
    .N(N),
    .W(W)
  ) u_enc (
    .vec  (onehot_in),
    .index(enc_index),
    .zero (enc_zero),
    .multi(enc_multi)
  );

  // capture when empty or when the held result drains this cycle
  always_comb begin
    capture  = sample && ((state == IDLE) || out_ready);
    drop     = sample && (state == HOLD) && !out_ready;
    illegal  = capture && (enc_zero || enc_multi);
    cnt_base = clr_err ? '0 : err_count;
  end

  // FSM, result registers and error bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_zero   <= 1'b0;
      out_multi  <= 1'b0;
      err_sticky <= 1'b0;
      ovr_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready && !sample) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase

      if (capture) begin
        out_index <= enc_index;
        out_zero  <= enc_zero;
        out_multi <= enc_multi;
      end

      err_sticky <= (err_sticky && !clr_err) || illegal;
      ovr_sticky <= (ovr_sticky && !clr_err) || drop;

      if (illegal && (cnt_base != CNT_MAX)) begin
        err_count <= cnt_base + CW'(1);
      end else begin
        err_count <= cnt_base;
      end
    end
  end

endmodule

// File: tb/tb_onehot_encoder_block.sv
// Directed bench for onehot_encoder_block.
// Inputs change 1ns after a rising edge; outputs are checked there.
module tb_onehot_encoder_block;

  logic       clk;
  logic       rst;
  logic [7:0] onehot_in;
  logic       sample;
  logic       out_ready;
  logic       clr_err;
  logic       out_valid;
  logic [2:0] out_index;
  logic       out_zero;
  logic       out_multi;
  logic       err_sticky;
  logic       ovr_sticky;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  onehot_encoder_block #(
    .N (8),
    .W (3),
    .CW(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .onehot_in (onehot_in),
    .sample    (sample),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .err_sticky(err_sticky),
    .ovr_sticky(ovr_sticky),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v,
                         input logic [2:0] idx, input logic z,
                         input logic m, input logic es,
                         input logic os, input logic [3:0] cnt);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".index"}, 32'(out_index), 32'(idx));
    chk({tag, ".zero"}, 32'(out_zero), 32'(z));
    chk({tag, ".multi"}, 32'(out_multi), 32'(m));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(es));
    chk({tag, ".ovr_sticky"}, 32'(ovr_sticky), 32'(os));
    chk({tag, ".err_count"}, 32'(err_count), 32'(cnt));
  endtask

  initial begin
    rst       = 1'b0;
    onehot_in = 8'h00;
    sample    = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    // legal capture of bit 5
    onehot_in = 8'b0010_0000;
    sample    = 1'b1;
    tick();
    chk_all("legal", 1, 5, 0, 0, 0, 0, 0);

    // drain to IDLE; result fields hold
    sample    = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_all("drain", 0, 5, 0, 0, 0, 0, 0);

    // zero vector
    onehot_in = 8'h00;
    sample    = 1'b1;
    tick();
    chk_all("zero_vec", 1, 0, 1, 0, 1, 0, 1);

    // multi-hot, captured straight from HOLD
    onehot_in = 8'b0000_1100;
    tick();
    chk_all("multi_vec", 1, 2, 0, 1, 1, 0, 2);

    // backpressure drops the sample
    out_ready = 1'b0;
    onehot_in = 8'h80;
    tick();
    chk_all("drop", 1, 2, 0, 1, 1, 1, 2);

    out_ready = 1'b1;
    sample    = 1'b0;
    tick();
    chk_all("drop_drain", 0, 2, 0, 1, 1, 1, 2);

    // back-to-back legal captures
    sample = 1'b1;
    onehot_in = 8'h01;
    tick();
    chk_all("b2b0", 1, 0, 0, 0, 1, 1, 2);
    onehot_in = 8'h02;
    tick();
    chk_all("b2b1", 1, 1, 0, 0, 1, 1, 2);
    onehot_in = 8'h04;
    tick();
    chk_all("b2b2", 1, 2, 0, 0, 1, 1, 2);
    onehot_in = 8'h08;
    tick();
    chk_all("b2b3", 1, 3, 0, 0, 1, 1, 2);

    // idle plus clear
    sample  = 1'b0;
    clr_err = 1'b1;
    tick();
    chk_all("clear", 0, 3, 0, 0, 0, 0, 0);
    clr_err = 1'b0;

    // 17 illegal captures saturate the counter
    sample    = 1'b1;
    onehot_in = 8'h03;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 13) chk("cnt14", 32'(err_count), 32'd14);
    end
    chk_all("sat", 1, 0, 0, 1, 1, 0, 15);

    // clear coincident with illegal capture
    clr_err   = 1'b1;
    onehot_in = 8'h00;
    tick();
    chk_all("clr_illegal", 1, 0, 1, 0, 1, 0, 1);

    // clear coincident with a dropped sample
    out_ready = 1'b0;
    onehot_in = 8'h40;
    tick();
    chk_all("clr_drop", 1, 0, 1, 0, 0, 1, 0);
    clr_err = 1'b0;

    // give a nonzero held index, then reset between edges
    out_ready = 1'b1;
    onehot_in = 8'h40;
    tick();
    chk_all("pre_rst", 1, 6, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // first edge after release captures
    out_ready = 1'b0;
    onehot_in = 8'h10;
    sample    = 1'b1;
    tick();
    chk_all("post_rst", 1, 4, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_block.md
ONEHOT_ENCODER_BLOCK -- requirements
Module: onehot_encoder_block

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the width of the one-hot state vector read from a chain of one-hot cells.
REQ-002 The block SHALL have parameter W, default 3, meaning the encoded index width, equal to clog2(N).
REQ-003 The block SHALL have parameter CW, default 4, meaning the error-counter width.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 onehot_in  input  N  one-hot state vector; bit i is the state output of cell i.
REQ-007 sample  input  1  request to capture onehot_in this cycle.
REQ-008 out_ready  input  1  consumer accepts the held result.
REQ-009 clr_err  input  1  synchronous clear of err_sticky, ovr_sticky and err_count.
REQ-010 out_valid  output  1  a captured result is held.
REQ-011 out_index  output  W  binary index of the captured vector.
REQ-012 out_zero  output  1  the captured vector had no bit set.
REQ-013 out_multi  output  1  the captured vector had more than one bit set.
REQ-014 err_sticky  output  1  an illegal vector has been captured since the last clear.
REQ-015 ovr_sticky  output  1  a sample was dropped since the last clear.
REQ-016 err_count  output  CW  saturating count of illegal captures.

Function
REQ-017 The FSM SHALL have two states: IDLE (out_valid=0) and HOLD (out_valid=1); out_valid SHALL be a registered decode of the state.
REQ-018 In IDLE with sample=1, the block SHALL capture onehot_in and enter HOLD; out_valid and the result fields SHALL be visible one cycle after the capture edge.
REQ-019 In HOLD with out_ready=1 and sample=0, the block SHALL return to IDLE.
REQ-020 In HOLD with out_ready=1 and sample=1, the block SHALL capture the new vector and stay in HOLD, sustaining one result per cycle.
REQ-021 In HOLD with out_ready=0 and sample=1, the block SHALL drop the sample, keep the held result unchanged, and set ovr_sticky.
REQ-022 out_index SHALL be the position of the lowest set bit; a zero vector SHALL encode index 0 with out_zero=1.
REQ-023 out_multi SHALL be set when two or more bits are set; out_zero and out_multi SHALL never both be 1.
REQ-024 Each captured vector with out_zero or out_multi SHALL set err_sticky and increment err_count, which saturates at 2^CW-1.
REQ-025 When clr_err coincides with an illegal capture, the clear SHALL apply first: err_count becomes 1 and err_sticky becomes 1.
REQ-026 When clr_err coincides with a dropped sample, ovr_sticky SHALL end at 1.
REQ-027 The result fields SHALL hold their last captured values in IDLE.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force state=IDLE, out_valid=0, out_index=0, out_zero=0, out_multi=0, err_sticky=0, ovr_sticky=0 and err_count=0.
REQ-029 When reset is asserted during HOLD, the held result SHALL be discarded.
REQ-030 After rst is released, the first capture SHALL be possible on the first rising edge.

Structure
REQ-031 The state enum and the default values of N, W and CW SHALL reside in the shared package onehot_pkg.
REQ-032 The priority encoding and legality checks SHALL live in the combinational sub-module onehot_prio_enc (inputs vec; outputs index, zero, multi).
REQ-033 The FSM and the counters SHALL be implemented in onehot_encoder_block.

Verification
REQ-034 Legal vector: onehot_in=8'b0010_0000 with sample=1 in IDLE -> next cycle out_valid=1, out_index=5, out_zero=0, out_multi=0, err_count=0.
REQ-035 Illegal vectors: a capture of 8'h00 -> out_index=0, out_zero=1, err_count=1; then a capture of 8'b0000_1100 -> out_index=2, out_multi=1, err_count=2, err_sticky=1.
REQ-036 Backpressure: HOLD with out_ready=0, then sample=1 with 8'h80 -> out_index unchanged and ovr_sticky=1; then out_ready=1 -> IDLE.
REQ-037 Back-to-back: out_ready=1 with sample=1 for 4 cycles of 8'h01, 8'h02, 8'h04 and 8'h08 -> out_index sequence 0,1,2,3 and out_valid high throughout.
REQ-038 Saturation and clear: 17 illegal captures -> err_count=15; then clr_err together with an illegal capture -> err_count=1.
REQ-039 Reset mid-HOLD: rst pulsed low between clock edges -> all outputs zero immediately, with no clock edge required.
